mm_tile_sequencer: RTL and testbench

Parametrised successor to the single-PE matrix-multiply control unit: sequences row fetch, row load, column-group fetch and PE issue over a run-time-sized R×C output, driving up to LANES processing elements per issue. It sits between the operand fetch/buffer logic and the PE array. It adds run-time dimensions, lane masking for partial column groups, abort, configuration-error reporting, and an optional stall-cycle counter.

---
 rtl/mm_tile_sequencer.sv | 174 +++++++++++++++++
 tb/tb_mm_tile_sequencer.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mm_tile_sequencer.sv
// rtl/mm_tile_sequencer.sv - row/column-group issue sequencer for a LANES-wide PE array
// Optional stall-cycle counter is built when MM_SEQ_STALL_CNT_EN is defined.
module mm_tile_sequencer #(
  parameter int N_MAX = 4,
  parameter int M_MAX = 4,
  parameter int LANES = 2,
  localparam int N_BIT_WIDTH = (N_MAX > 1) ? $clog2(N_MAX) : 1,
  localparam int M_BIT_WIDTH = (M_MAX > 1) ? $clog2(M_MAX) : 1,
  localparam int RW = $clog2(N_MAX + 1),
  localparam int CW = $clog2(M_MAX + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [RW-1:0]          cfg_rows,
  input  logic [CW-1:0]          cfg_cols,
  input  logic                   fetch_stall,
  input  logic                   fifo_full,
  input  logic                   PE_ready,
  input  logic                   data_stall,
  output logic                   fetch_row,
  output logic                   load_row,
  output logic                   fetch_col,
  output logic                   start_PE,
  output logic [LANES-1:0]       lane_mask,
  output logic [N_BIT_WIDTH-1:0] n,
  output logic [M_BIT_WIDTH-1:0] m,
  output logic                   busy,
  output logic                   done,
  output logic                   aborted,
  output logic                   cfg_err,
  output logic [31:0]            stall_cycles
);

  localparam int NW = RW + 1;
  localparam int MW = M_BIT_WIDTH + 1;

  typedef enum logic [2:0] {
    IDLE, FETCH_ROW, PREP_ROW, FETCH_COL, ISSUE_PE, ADVANCE, DRAIN
  } state_t;

  state_t        state;
  logic [RW-1:0] rows_q;
  logic [CW-1:0] cols_q;
  logic          can_fetch;
  logic          can_issue;
  logic          cfg_bad;
  logic          accept;
  logic          kill;
  logic          last_group;
  logic          last_row;
  logic [MW-1:0] m_next;

  assign can_fetch  = PE_ready & ~fetch_stall;
  assign can_issue  = PE_ready & ~fifo_full & ~data_stall;
  assign cfg_bad    = (cfg_rows == '0) || (cfg_cols == '0) ||
                      (cfg_rows > RW'(N_MAX)) || (cfg_cols > CW'(M_MAX));
  assign busy       = (state != IDLE);
  assign accept     = (state == IDLE) & start & ~cfg_bad;
  assign kill       = busy & abort;
  // Comparisons run one bit wider than m so m+LANES cannot wrap.
  assign m_next     = MW'(m) + MW'(LANES);
  assign last_group = (m_next >= MW'(cols_q));
  assign last_row   = ((NW'(n) + NW'(1)) == NW'(rows_q));

  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_mask[i] = ((MW'(m) + MW'(i)) < MW'(cols_q));
    end
  end

  // Pulses are decoded from state so a stalled state simply re-evaluates next cycle.
  always_comb begin
    fetch_row = 1'b0;
    load_row  = 1'b0;
    fetch_col = 1'b0;
    start_PE  = 1'b0;
    cfg_err   = (state == IDLE) & start & cfg_bad;
    if (!kill) begin
      case (state)
        FETCH_ROW: fetch_row = can_fetch;
        PREP_ROW:  load_row  = ~data_stall;
        FETCH_COL: fetch_col = can_fetch;
        ISSUE_PE:  start_PE  = can_issue;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      n       <= '0;
      m       <= '0;
      rows_q  <= '0;
      cols_q  <= '0;
      done    <= 1'b0;
      aborted <= 1'b0;
    end else if (kill) begin
      state   <= IDLE;
      aborted <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rows_q  <= cfg_rows;
            cols_q  <= cfg_cols;
            n       <= '0;
            m       <= '0;
            done    <= 1'b0;
            aborted <= 1'b0;
            state   <= FETCH_ROW;
          end
        end
        FETCH_ROW: if (can_fetch)   state <= PREP_ROW;
        PREP_ROW:  if (!data_stall) state <= FETCH_COL;
        FETCH_COL: if (can_fetch)   state <= ISSUE_PE;
        ISSUE_PE:  if (can_issue)   state <= ADVANCE;
        ADVANCE: begin
          if (last_group && last_row) begin
            state <= DRAIN;
          end else if (last_group) begin
            m     <= '0;
            n     <= n + N_BIT_WIDTH'(1);
            state <= FETCH_ROW;
          end else begin
            m     <= M_BIT_WIDTH'(m_next);
            state <= FETCH_COL;
          end
        end
        DRAIN: begin
          if (PE_ready) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MM_SEQ_STALL_CNT_EN
  logic        stalled;
  logic [31:0] stall_q;

  always_comb begin
    stalled = 1'b0;
    case (state)
      FETCH_ROW: stalled = ~can_fetch;
      PREP_ROW:  stalled = data_stall;
      FETCH_COL: stalled = ~can_fetch;
      ISSUE_PE:  stalled = ~can_issue;
      DRAIN:     stalled = ~PE_ready;
      default:   stalled = 1'b0;
    endcase
  end

  // An aborted cycle leaves its state, so it is not counted as a stall.
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      stall_q <= '0;
    end else if (stalled && !abort && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_mm_tile_sequencer.sv
// tb/tb_mm_tile_sequencer.sv - self-checking bench for mm_tile_sequencer
// Expected issue order, counts and timing come from a loop-nest model of the tile walk.
module tb_mm_tile_sequencer;
  localparam int N_MAX = 4;
  localparam int M_MAX = 4;
  localparam int LANES = 2;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [2:0]  cfg_rows, cfg_cols;
  logic        fetch_stall, fifo_full, PE_ready, data_stall;
  logic        fetch_row, load_row, fetch_col, start_PE;
  logic [1:0]  lane_mask, n, m;
  logic        busy, done, aborted, cfg_err;
  logic [31:0] stall_cycles;

  int checks = 0;
  int errors = 0;
  int bp_level = 0;
  logic ff_force = 1'b0;

  logic        s_busy, s_done, s_aborted, s_cfg_err, s_start_pe;
  logic [31:0] s_stall;
  logic [13:0] s_vec;
  int obs_fetch_row, obs_load_row, obs_fetch_col;
  int obs_n[$], obs_m[$], obs_mask[$];

  mm_tile_sequencer #(.N_MAX(N_MAX), .M_MAX(M_MAX), .LANES(LANES)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_rows(cfg_rows), .cfg_cols(cfg_cols),
    .fetch_stall(fetch_stall), .fifo_full(fifo_full), .PE_ready(PE_ready), .data_stall(data_stall),
    .fetch_row(fetch_row), .load_row(load_row), .fetch_col(fetch_col), .start_PE(start_PE),
    .lane_mask(lane_mask), .n(n), .m(m), .busy(busy), .done(done), .aborted(aborted),
    .cfg_err(cfg_err), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_obs();
    obs_fetch_row = 0;
    obs_load_row  = 0;
    obs_fetch_col = 0;
    obs_n.delete();
    obs_m.delete();
    obs_mask.delete();
  endtask

  // One clock: drive backpressure, sample at the falling edge, advance past the rising edge.
  task automatic step();
    if (bp_level > 0) begin
      fetch_stall = ($urandom_range(99) < bp_level);
      data_stall  = ($urandom_range(99) < bp_level);
      fifo_full   = ($urandom_range(99) < bp_level);
      PE_ready    = !($urandom_range(99) < bp_level);
    end else begin
      fetch_stall = 1'b0;
      data_stall  = 1'b0;
      fifo_full   = 1'b0;
      PE_ready    = 1'b1;
    end
    if (ff_force) fifo_full = 1'b1;
    @(negedge clk);
    s_busy     = busy;
    s_done     = done;
    s_aborted  = aborted;
    s_cfg_err  = cfg_err;
    s_start_pe = start_PE;
    s_stall    = stall_cycles;
    s_vec      = {busy, done, aborted, cfg_err, fetch_row, load_row, fetch_col, start_PE, lane_mask, n, m};
    if (fetch_row) obs_fetch_row++;
    if (load_row)  obs_load_row++;
    if (fetch_col) obs_fetch_col++;
    if (start_PE) begin
      obs_n.push_back(int'(n));
      obs_m.push_back(int'(m));
      obs_mask.push_back(int'(lane_mask));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_check(input int r, input int c, input string name);
    int g, nominal, total, done_step, exp_stall;
    int exp_n[$], exp_m[$], exp_mask[$];
    g = (c + LANES - 1) / LANES;
    nominal = r * (5 + 3 * (g - 1)) + 1;
    for (int rr = 0; rr < r; rr++) begin
      for (int mm = 0; mm < c; mm += LANES) begin
        int mask;
        mask = 0;
        for (int i = 0; i < LANES; i++) if (mm + i < c) mask |= (1 << i);
        exp_n.push_back(rr);
        exp_m.push_back(mm);
        exp_mask.push_back(mask);
      end
    end
    clear_obs();
    cfg_rows = 3'(r);
    cfg_cols = 3'(c);
    start = 1'b1;
    step();
    start = 1'b0;
    done_step = -1;
    for (int j = 1; j < 4000; j++) begin
      if (j == 2) begin
        start    = 1'b1;
        cfg_rows = 3'($urandom_range(1, N_MAX));
        cfg_cols = 3'($urandom_range(1, M_MAX));
      end
      step();
      start = 1'b0;
      if (s_done) begin
        done_step = j;
        break;
      end
    end
    checks++;
    if (done_step < 0) begin
      errors++;
      $display("FAIL %s_timeout: done never rose, required within 4000 cycles", name);
      return;
    end
    total = done_step - 1;
`ifdef MM_SEQ_STALL_CNT_EN
    exp_stall = total - nominal;
`else
    exp_stall = 0;
`endif
    checks++;
    if (total < nominal || (bp_level == 0 && total != nominal)) begin
      errors++;
      $display("FAIL %s_latency: done after edge %0d, required %0d (bp %0d)", name, total, nominal, bp_level);
    end
    checks++;
    if (s_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy_at_done: got %b, required 0", name, s_busy);
    end
    checks++;
    if (obs_fetch_row != r || obs_load_row != r || obs_fetch_col != r * g) begin
      errors++;
      $display("FAIL %s_pulse_counts: fetch_row %0d load_row %0d fetch_col %0d, required %0d %0d %0d",
               name, obs_fetch_row, obs_load_row, obs_fetch_col, r, r, r * g);
    end
    checks++;
    if (obs_n.size() != exp_n.size()) begin
      errors++;
      $display("FAIL %s_issue_count: got %0d start_PE, required %0d", name, obs_n.size(), exp_n.size());
    end else begin
      for (int k = 0; k < exp_n.size(); k++) begin
        checks++;
        if (obs_n[k] != exp_n[k] || obs_m[k] != exp_m[k] || obs_mask[k] != exp_mask[k]) begin
          errors++;
          $display("FAIL %s_issue%0d: got n=%0d m=%0d mask=%0d, required n=%0d m=%0d mask=%0d",
                   name, k, obs_n[k], obs_m[k], obs_mask[k], exp_n[k], exp_m[k], exp_mask[k]);
        end
      end
    end
    checks++;
    if (s_stall !== 32'(exp_stall)) begin
      errors++;
      $display("FAIL %s_stall_cycles: got %0d, required %0d", name, s_stall, exp_stall);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++;
    if (s_vec !== 14'd0 || s_stall !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: got vec=%b stall=%0d, required all zero", s_vec, s_stall);
    end
  endtask

  task automatic test_single_group();
    run_check(1, 1, "single");
  endtask

  task automatic test_multi_row();
    run_check(2, 3, "r2c3");
  endtask

  task automatic test_fifo_stall();
    int first_pe, done_step;
    first_pe = -1;
    done_step = -1;
    cfg_rows = 3'd1;
    cfg_cols = 3'd2;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int j = 1; j < 40; j++) begin
      ff_force = (j >= 4 && j <= 8);
      step();
      if (s_start_pe && first_pe < 0) first_pe = j;
      if (s_done) begin
        done_step = j;
        break;
      end
    end
    ff_force = 1'b0;
    checks++;
    if (first_pe != 9) begin
      errors++;
      $display("FAIL fifo_stall_issue: start_PE at cycle %0d, required 9", first_pe);
    end
    checks++;
    if (done_step != 12) begin
      errors++;
      $display("FAIL fifo_stall_done: done at cycle %0d, required 12", done_step);
    end
    checks++;
`ifdef MM_SEQ_STALL_CNT_EN
    if (s_stall !== 32'd5) begin
      errors++;
      $display("FAIL fifo_stall_count: got %0d, required 5", s_stall);
    end
`else
    if (s_stall !== 32'd0) begin
      errors++;
      $display("FAIL fifo_stall_count: got %0d, required 0", s_stall);
    end
`endif
  endtask

  task automatic test_abort();
    int done_step;
    clear_obs();
    cfg_rows = 3'd2;
    cfg_cols = 3'd4;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if (s_start_pe !== 1'b0 || obs_n.size() != 0) begin
      errors++;
      $display("FAIL abort_suppress: start_PE=%b issues=%0d, required 0 and 0", s_start_pe, obs_n.size());
    end
    step();
    checks++;
    if (s_busy !== 1'b0 || s_aborted !== 1'b1 || s_done !== 1'b0) begin
      errors++;
      $display("FAIL abort_state: busy=%b aborted=%b done=%b, required 0 1 0", s_busy, s_aborted, s_done);
    end
    cfg_rows = 3'd1;
    cfg_cols = 3'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    checks++;
    if (s_aborted !== 1'b0 || s_busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_cleared: aborted=%b busy=%b, required 0 1", s_aborted, s_busy);
    end
    done_step = -1;
    for (int j = 0; j < 20; j++) begin
      step();
      if (s_done) begin
        done_step = j;
        break;
      end
    end
    checks++;
    if (done_step < 0) begin
      errors++;
      $display("FAIL abort_rerun: done never rose, required within 20 cycles");
    end
  endtask

  task automatic test_abort_drain();
    cfg_rows = 3'd1;
    cfg_cols = 3'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int j = 1; j <= 5; j++) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    step();
    checks++;
    if (s_done !== 1'b0 || s_aborted !== 1'b1 || s_busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_drain: done=%b aborted=%b busy=%b, required 0 1 0", s_done, s_aborted, s_busy);
    end
  endtask

  task automatic test_abort_idle_start();
    int done_step;
    cfg_rows = 3'd1;
    cfg_cols = 3'd1;
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    step();
    checks++;
    if (s_busy !== 1'b1 || s_aborted !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle_start: busy=%b aborted=%b, required 1 0", s_busy, s_aborted);
    end
    done_step = -1;
    for (int j = 0; j < 20; j++) begin
      step();
      if (s_done) begin
        done_step = j;
        break;
      end
    end
    checks++;
    if (done_step < 0) begin
      errors++;
      $display("FAIL abort_idle_done: done never rose, required within 20 cycles");
    end
  endtask

  task automatic test_cfg_err();
    run_check(1, 2, "pre_cfg");
    cfg_rows = 3'd1;
    cfg_cols = 3'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (s_cfg_err !== 1'b1) begin
      errors++;
      $display("FAIL cfg_err_cols0: got %b, required 1", s_cfg_err);
    end
    step();
    checks++;
    if (s_busy !== 1'b0 || s_done !== 1'b1 || s_cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL cfg_err_after0: busy=%b done=%b cfg_err=%b, required 0 1 0", s_busy, s_done, s_cfg_err);
    end
    cfg_rows = 3'(N_MAX + 1);
    cfg_cols = 3'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (s_cfg_err !== 1'b1) begin
      errors++;
      $display("FAIL cfg_err_rows: got %b, required 1", s_cfg_err);
    end
    step();
    checks++;
    if (s_busy !== 1'b0 || s_done !== 1'b1) begin
      errors++;
      $display("FAIL cfg_err_after_rows: busy=%b done=%b, required 0 1", s_busy, s_done);
    end
  endtask

  task automatic test_reset_mid_run();
    cfg_rows = 3'd2;
    cfg_cols = 3'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int j = 1; j <= 4; j++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    checks++;
    if (s_vec !== 14'd0 || s_stall !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_run: got vec=%b stall=%0d, required all zero", s_vec, s_stall);
    end
    run_check(2, 3, "after_rst");
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      bp_level = $urandom_range(0, 40);
      run_check($urandom_range(1, N_MAX), $urandom_range(1, M_MAX), $sformatf("rand%0d", t));
    end
    bp_level = 0;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    cfg_rows = 3'd0;
    cfg_cols = 3'd0;
    fetch_stall = 1'b0;
    fifo_full = 1'b0;
    PE_ready = 1'b1;
    data_stall = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_single_group();
    test_multi_row();
    test_fifo_stall();
    test_abort();
    test_abort_drain();
    test_abort_idle_start();
    test_cfg_err();
    test_reset_mid_run();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
